// File: rtl/instr_encoder_pkg.sv
// Shared RV32I opcode values, format selectors and immediate range helpers
// used by the instruction encoder.
package instr_encoder_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_U, FMT_J, FMT_I, FMT_S, FMT_B, FMT_R, FMT_SHIFT, FMT_BAD
  } fmt_e;

  // True when v is representable as an n-bit two's-complement value.
  function automatic logic fits_s(input logic [31:0] v, input int unsigned n);
    logic [31:0] s;
    s = 32'($signed(v) >>> (n - 1));
    return (s == '0) || (s == '1);
  endfunction

  function automatic fmt_e fmt_sel(input logic [6:0] opc, input logic [2:0] f3);
    case (opc)
      OPC_LUI, OPC_AUIPC: return FMT_U;
      OPC_JAL:            return FMT_J;
      OPC_JALR, OPC_LOAD: return FMT_I;
      OPC_STORE:          return FMT_S;
      OPC_BRANCH:         return FMT_B;
      OPC_ARI_RTYPE:      return FMT_R;
      OPC_ARI_ITYPE:      return (f3 == 3'b001 || f3 == 3'b101) ? FMT_SHIFT : FMT_I;
      default:            return FMT_BAD;
    endcase
  endfunction

endpackage

// File: rtl/instr_encoder_sync_fifo.sv
// Fall-through synchronous FIFO: the head entry is visible on dout_o in the
// cycle after it was pushed. Power-of-two depth; pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    cnt_q;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == LW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign level_o = cnt_q;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs RV32I fields into instruction words, drops field sets with illegal
// opcodes or out-of-range immediates, and streams legal words to IMEM.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [XLEN-1:0]   imm,
  input  logic              load_addr,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [XLEN-1:0]   imem_din,
  output logic              err,
  output logic [7:0]        drop_cnt,
  output logic [LW-1:0]     level
);

  fmt_e             fmt;
  logic [XLEN-1:0]  word;
  logic             legal;
  logic             accept, push, pop, full, empty;
  logic [XLEN-1:0]  fifo_dout;
  logic             rdy_q, err_q;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign fmt = fmt_sel(opcode, funct3);

  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (fmt)
      FMT_U: begin
        legal = (imm[11:0] == 12'h000);
        word  = {imm[31:12], rd, opcode};
      end
      FMT_J: begin
        legal = ~imm[0] & fits_s(imm, 21);
        word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      end
      FMT_I: begin
        legal = fits_s(imm, 12);
        word  = {imm[11:0], rs1, funct3, rd, opcode};
      end
      FMT_S: begin
        legal = fits_s(imm, 12);
        word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      end
      FMT_B: begin
        legal = ~imm[0] & fits_s(imm, 13);
        word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      end
      FMT_R: begin
        legal = 1'b1;
        word  = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      FMT_SHIFT: begin
        legal = (imm[31:5] == '0);
        word  = {funct7, imm[4:0], rs1, funct3, rd, opcode};
      end
      default: ;
    endcase
  end

  // rdy_q keeps in_ready low through reset and raises it one edge after release.
  assign in_ready = rdy_q & ~full;
  assign accept   = in_valid & in_ready;
  assign push     = accept & legal;
  assign pop      = imem_we & imem_ready;

  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (word),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign imem_we   = ~empty;
  assign imem_din  = empty ? '0 : fifo_dout;
  assign imem_addr = addr_q;
  assign err       = err_q;
  assign drop_cnt  = drop_cnt_q;

  always_comb begin
    addr_d = addr_q;
    if (load_addr)  addr_d = start_addr;
    else if (pop)   addr_d = addr_q + 1'b1;
  end

  assign drop_cnt_d = (drop_cnt_q == 8'hFF) ? drop_cnt_q : drop_cnt_q + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q      <= 1'b0;
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
      addr_q     <= ADDR_W'(BASE_ADDR);
    end else begin
      rdy_q  <= 1'b1;
      addr_q <= addr_d;
      if (accept && !legal) begin
        err_q      <= 1'b1;
        drop_cnt_q <= drop_cnt_d;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded RV32I words, backpressure,
// illegal drops, address reload/wrap and asynchronous reset mid-burst.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm;
  logic        load_addr;
  logic [11:0] start_addr;
  logic        imem_we, imem_ready;
  logic [11:0] imem_addr;
  logic [31:0] imem_din;
  logic        err;
  logic [7:0]  drop_cnt;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int          wr_cyc[$];
  logic [11:0] wr_addr[$];
  logic [31:0] wr_data[$];

  instr_encoder #(.XLEN(32), .DEPTH(4), .ADDR_W(12), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .load_addr(load_addr), .start_addr(start_addr),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_din(imem_din), .err(err), .drop_cnt(drop_cnt), .level(level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (imem_we && imem_ready) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_din);
    end
  end

  task automatic clear_log();
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [6:0] f7,
                      input logic [31:0] im);
    in_valid = 1'b1; opcode = op; rd = d; funct3 = f3;
    rs1 = s1; rs2 = s2; funct7 = f7; imm = im;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; load_addr = 1'b0; imem_ready = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    clear_log();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; load_addr = 1'b0; start_addr = '0; imem_ready = 1'b1;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    idle(2);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", imem_we); end
    checks++; if (imem_addr !== 12'h000) begin errors++; $display("FAIL reset_addr got %h want 000", imem_addr); end
    checks++; if (imem_din !== 32'h0) begin errors++; $display("FAIL reset_din got %h want 0", imem_din); end
    checks++; if ({err, drop_cnt, level} !== 12'h0) begin errors++; $display("FAIL reset_status got err=%b drop=%0d lvl=%0d want 0", err, drop_cnt, level); end
    rst_n = 1'b1;
    idle(1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_single_itype();
    do_reset();
    send(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
    checks++; if (imem_we !== 1'b1 || imem_din !== 32'h00500093 || imem_addr !== 12'h000) begin
      errors++; $display("FAIL single_next_cycle got we=%b din=%h addr=%h want 1 00500093 000", imem_we, imem_din, imem_addr); end
    idle(3);
    checks++; if (wr_addr.size() !== 1) begin errors++; $display("FAIL single_count got %0d want 1", wr_addr.size()); end
    else begin
      checks++; if (wr_addr[0] !== 12'h000 || wr_data[0] !== 32'h00500093) begin
        errors++; $display("FAIL single_write got %h@%h want 00500093@000", wr_data[0], wr_addr[0]); end
    end
    checks++; if (imem_we !== 1'b0 || imem_din !== 32'h0) begin errors++; $display("FAIL single_empty got we=%b din=%h want 0 0", imem_we, imem_din); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp[7];
    exp = '{32'h12345137, 32'hFE20AE23, 32'hFE000CE3, 32'h001000EF,
            32'h00309093, 32'h4030D093, 32'h002081B3};
    do_reset();
    send(7'b0110111, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000);   // lui x2
    send(7'b0100011, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'hFFFFFFFC);   // sw x2,-4(x1)
    send(7'b1100011, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFFFF8);   // beq x0,x0,-8
    send(7'b1101111, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h00000800);   // jal x1,2048
    send(7'b0010011, 5'd1, 3'd1, 5'd1, 5'd0, 7'h00, 32'd3);         // slli x1,x1,3
    send(7'b0010011, 5'd1, 3'd5, 5'd1, 5'd0, 7'h20, 32'd3);         // srai x1,x1,3
    send(7'b0110011, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00, 32'hDEADBEEF);  // add x3,x1,x2
    idle(3);
    checks++; if (wr_addr.size() !== 7) begin errors++; $display("FAIL b2b_count got %0d want 7", wr_addr.size()); end
    else for (int i = 0; i < 7; i++) begin
      checks++; if (wr_addr[i] !== 12'(i) || wr_data[i] !== exp[i] || wr_cyc[i] !== wr_cyc[0] + i) begin
        errors++; $display("FAIL b2b_word%0d got %h@%h cyc+%0d want %h@%h cyc+%0d", i, wr_data[i], wr_addr[i], wr_cyc[i] - wr_cyc[0], exp[i], i, i); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    imem_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_before%0d got %b want 1", i, in_ready); end
      send(7'b0010011, 5'(i), 3'd0, 5'd0, 5'd0, 7'd0, 32'(i));
    end
    idle(2);
    checks++; if (in_ready !== 1'b0 || level !== 3'd4) begin errors++; $display("FAIL bp_full got rdy=%b lvl=%0d want 0 4", in_ready, level); end
    checks++; if (imem_we !== 1'b1 || imem_addr !== 12'h000 || imem_din !== 32'h00100093) begin
      errors++; $display("FAIL bp_hold got we=%b %h@%h want 1 00100093@000", imem_we, imem_din, imem_addr); end
    imem_ready = 1'b1;
    idle(6);
    checks++; if (wr_addr.size() !== 4) begin errors++; $display("FAIL bp_count got %0d want 4", wr_addr.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (wr_addr[i] !== 12'(i) || wr_data[i] !== ((32'(i + 1) << 20) | (32'(i + 1) << 7) | 32'h13) || wr_cyc[i] !== wr_cyc[0] + i) begin
        errors++; $display("FAIL bp_word%0d got %h@%h cyc+%0d", i, wr_data[i], wr_addr[i], wr_cyc[i] - wr_cyc[0]); end
    end
    checks++; if (imem_we !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL bp_drained got we=%b lvl=%0d want 0 0", imem_we, level); end
  endtask

  task automatic test_illegal();
    do_reset();
    send(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);      // addi imm too large
    checks++; if (err !== 1'b1 || drop_cnt !== 8'd1 || imem_we !== 1'b0) begin
      errors++; $display("FAIL ill_imm got err=%b drop=%0d we=%b want 1 1 0", err, drop_cnt, imem_we); end
    send(7'h7F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);               // bad opcode
    checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL ill_opc got drop=%0d want 2", drop_cnt); end
    send(7'b1101111, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd3);          // jal odd
    send(7'b1100011, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd4096);       // beq past +4094
    send(7'b0010011, 5'd1, 3'd1, 5'd1, 5'd0, 7'd0, 32'd32);         // slli shamt 32
    send(7'b0110111, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h00001001);   // lui low bits set
    checks++; if (drop_cnt !== 8'd6 || level !== 3'd0 || err !== 1'b1) begin
      errors++; $display("FAIL ill_bounds got drop=%0d lvl=%0d err=%b want 6 0 1", drop_cnt, level, err); end
    send(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFF800);   // addi -2048 legal
    send(7'b1100011, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd4094);       // beq +4094 legal
    idle(3);
    checks++; if (wr_addr.size() !== 2) begin errors++; $display("FAIL ill_follow_count got %0d want 2", wr_addr.size()); end
    else begin
      checks++; if (wr_addr[0] !== 12'h000 || wr_data[0] !== 32'h80000093) begin
        errors++; $display("FAIL ill_follow0 got %h@%h want 80000093@000", wr_data[0], wr_addr[0]); end
      checks++; if (wr_addr[1] !== 12'h001 || wr_data[1] !== 32'h7E000FE3) begin
        errors++; $display("FAIL ill_follow1 got %h@%h want 7E000FE3@001", wr_data[1], wr_addr[1]); end
    end
    checks++; if (err !== 1'b1 || drop_cnt !== 8'd6) begin errors++; $display("FAIL ill_sticky got err=%b drop=%0d want 1 6", err, drop_cnt); end
  endtask

  task automatic test_drop_saturate();
    do_reset();
    in_valid = 1'b1; opcode = 7'h7F;
    repeat (260) @(negedge clk);
    in_valid = 1'b0;
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_sat got %0d want 255", drop_cnt); end
  endtask

  task automatic test_addr_reload();
    do_reset();
    load_addr = 1'b1; start_addr = 12'h005;
    idle(1);
    load_addr = 1'b0;
    checks++; if (imem_addr !== 12'h005) begin errors++; $display("FAIL reload_init got %h want 005", imem_addr); end
    imem_ready = 1'b0;
    send(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1);
    send(7'b0010011, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2);
    imem_ready = 1'b1; load_addr = 1'b1; start_addr = 12'h100;
    idle(1);
    load_addr = 1'b0;
    idle(3);
    checks++; if (wr_addr.size() !== 2) begin errors++; $display("FAIL reload_count got %0d want 2", wr_addr.size()); end
    else begin
      checks++; if (wr_addr[0] !== 12'h005 || wr_data[0] !== 32'h00100093) begin
        errors++; $display("FAIL reload_old got %h@%h want 00100093@005", wr_data[0], wr_addr[0]); end
      checks++; if (wr_addr[1] !== 12'h100 || wr_data[1] !== 32'h00200113) begin
        errors++; $display("FAIL reload_new got %h@%h want 00200113@100", wr_data[1], wr_addr[1]); end
    end
    clear_log();
    load_addr = 1'b1; start_addr = 12'hFFF;
    idle(1);
    load_addr = 1'b0;
    send(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1);
    send(7'b0010011, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2);
    idle(3);
    checks++; if (wr_addr.size() !== 2) begin errors++; $display("FAIL wrap_count got %0d want 2", wr_addr.size()); end
    else begin
      checks++; if (wr_addr[0] !== 12'hFFF || wr_addr[1] !== 12'h000) begin
        errors++; $display("FAIL wrap_addr got %h,%h want FFF,000", wr_addr[0], wr_addr[1]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    imem_ready = 1'b0;
    for (int i = 1; i <= 3; i++) send(7'b0010011, 5'(i), 3'd0, 5'd0, 5'd0, 7'd0, 32'(i));
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL mid_level got %0d want 3", level); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (imem_we !== 1'b0 || level !== 3'd0 || imem_addr !== 12'h000 || imem_din !== 32'h0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_async got we=%b lvl=%0d addr=%h din=%h rdy=%b want 0 0 000 0 0", imem_we, level, imem_addr, imem_din, in_ready); end
    imem_ready = 1'b1;
    idle(2);
    rst_n = 1'b1;
    clear_log();
    idle(5);
    checks++; if (wr_addr.size() !== 0 || imem_we !== 1'b0) begin
      errors++; $display("FAIL mid_after got writes=%0d we=%b want 0 0", wr_addr.size(), imem_we); end
  endtask

  initial begin
    test_reset();
    test_single_itype();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_drop_saturate();
    test_addr_reload();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
